ts_pkt_arb: RTL and testbench

Packet-level round-robin arbiter that shares one MPEG-TS datapath, the PCR processing stage, among CH_NUM upstream packet buffers. Each buffer flags when it holds one complete 188-byte packet. The arbiter grants one channel at a time and drains exactly one packet from it with a byte-read strobe. It re-times the returned bytes onto a single ts_sync/ts_valid/ts_data stream in the clk_341m domain.

---
 rtl/ts_pkt_arb.sv | 136 +++++++++++++
 tb/tb_ts_pkt_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_pkt_arb.sv
// Packet-level round-robin arbiter feeding the PCR stage: grants one channel at a time,
// drains exactly one TS packet from it and re-times the bytes onto one ts_* stream.
module ts_pkt_arb #(
  parameter int CH_NUM  = 4,
  parameter int PKT_LEN = 188,
  parameter int MIN_GAP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     ch_ena_i,
  input  logic [CH_NUM-1:0]     pkt_rdy_i,
  output logic [CH_NUM-1:0]     pkt_rd_o,
  input  logic [8*CH_NUM-1:0]   in_data_i,
  output logic                  ts_sync_o,
  output logic                  ts_valid_o,
  output logic [7:0]            ts_data_o,
  output logic [2:0]            ts_ch_o,
  output logic                  sync_err_o
);

  localparam int         CW        = $clog2(CH_NUM);
  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
  localparam logic [3:0] LAST_GAP  = 4'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {IDLE, READ, GAP} state_e;

  state_e              state_q;
  logic [CW-1:0]       gnt_q;       // current grant; also the round-robin pointer (last_gr)
  logic [7:0]          byte_cnt_q;
  logic [3:0]          gap_cnt_q;
  logic [CH_NUM-1:0]   pkt_rd_q;

  logic                rd_d1_q;
  logic                first_d1_q;
  logic                ts_sync_q;
  logic                ts_valid_q;
  logic [7:0]          ts_data_q;
  logic [2:0]          ts_ch_q;
  logic                sync_err_q;

  logic [CH_NUM-1:0]   elig;
  logic                pick_vld;
  logic [CW-1:0]       pick_idx;
  logic [CW-1:0]       cand;
  logic [7:0]          lane;

  // Rotating-priority search starting just above the previous grant.
  always_comb begin
    // NOTE: every combinational output is given a default first so no path infers a latch.
    elig     = pkt_rdy_i & ch_ena_i;
    pick_vld = 1'b0;
    pick_idx = gnt_q;
    cand     = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      cand = CW'((int'(gnt_q) + k) % CH_NUM);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    lane = 8'h00;
    for (int i = 0; i < CH_NUM; i++) begin
      if (gnt_q == CW'(i)) lane = in_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= CW'(CH_NUM - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pkt_rd_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_q      <= pick_idx;
            byte_cnt_q <= '0;
            pkt_rd_q   <= CH_NUM'(1) << pick_idx;
            state_q    <= READ;
          end
        end
        READ: begin
          if (byte_cnt_q == LAST_BYTE) begin
            pkt_rd_q  <= '0;
            gap_cnt_q <= '0;
            state_q   <= (MIN_GAP > 0) ? GAP : IDLE;
          end else begin
            byte_cnt_q <= byte_cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt_q == LAST_GAP) state_q   <= IDLE;
          else                       gap_cnt_q <= gap_cnt_q + 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer returns the byte one cycle after the strobe; register it one more time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1_q    <= 1'b0;
      first_d1_q <= 1'b0;
      ts_sync_q  <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_data_q  <= 8'h00;
      ts_ch_q    <= 3'd0;
      sync_err_q <= 1'b0;
    end else begin
      rd_d1_q    <= |pkt_rd_q;
      first_d1_q <= (state_q == READ) && (byte_cnt_q == 8'd0);
      ts_valid_q <= rd_d1_q;
      ts_sync_q  <= rd_d1_q && first_d1_q;
      sync_err_q <= first_d1_q && (lane != SYNC_BYTE);
      if (rd_d1_q)               ts_data_q <= lane;
      if (rd_d1_q && first_d1_q) ts_ch_q   <= 3'(gnt_q);
    end
  end

  assign pkt_rd_o   = pkt_rd_q;
  assign ts_sync_o  = ts_sync_q;
  assign ts_valid_o = ts_valid_q;
  assign ts_data_o  = ts_data_q;
  assign ts_ch_o    = ts_ch_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: tb/tb_ts_pkt_arb.sv
// Bench for ts_pkt_arb: emulated packet buffers, a transaction-timed reference model
// compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_ts_pkt_arb;

  localparam int CH  = 4;
  localparam int LEN = 188;
  localparam int GAP = 4;
  localparam int PERIOD = LEN + GAP + 1;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH-1:0]   ch_ena;
  logic [CH-1:0]   pkt_rdy;
  logic [CH-1:0]   pkt_rd;
  logic [8*CH-1:0] in_data;
  logic            ts_sync, ts_valid, sync_err;
  logic [7:0]      ts_data;
  logic [2:0]      ts_ch;

  logic [CH-1:0]   b_rd;
  logic            b_sync, b_valid, b_err;
  logic [7:0]      b_data;
  logic [2:0]      b_ch;

  always #5 clk = ~clk;

  ts_pkt_arb #(.CH_NUM(CH), .PKT_LEN(LEN), .MIN_GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_ena_i(ch_ena), .pkt_rdy_i(pkt_rdy), .pkt_rd_o(pkt_rd),
    .in_data_i(in_data), .ts_sync_o(ts_sync), .ts_valid_o(ts_valid), .ts_data_o(ts_data),
    .ts_ch_o(ts_ch), .sync_err_o(sync_err));

  // Second instance with no forced gap and one always-ready channel.
  ts_pkt_arb #(.CH_NUM(CH), .PKT_LEN(LEN), .MIN_GAP(0)) u_b2b (
    .clk(clk), .rst_n(rst_n), .ch_ena_i(4'b0001), .pkt_rdy_i(4'b0001), .pkt_rd_o(b_rd),
    .in_data_i({4{8'h47}}), .ts_sync_o(b_sync), .ts_valid_o(b_valid), .ts_data_o(b_data),
    .ts_ch_o(b_ch), .sync_err_o(b_err));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream packet buffers.
  logic [7:0] pkt [CH][LEN];
  int         rd_ptr [CH];
  int         avail [CH];
  logic [7:0] first_byte [CH];
  bit         ramp [CH];

  task automatic gen_pkt(input int c);
    pkt[c][0] = first_byte[c];
    for (int k = 1; k < LEN; k++)
      pkt[c][k] = ramp[c] ? 8'(k - 1) : 8'($urandom_range(0, 255));
  endtask

  task automatic upd_rdy();
    for (int c = 0; c < CH; c++) pkt_rdy[c] = (avail[c] > 0);
  endtask

  initial begin
    logic [CH-1:0] seen;
    forever begin
      @(negedge clk);
      seen = pkt_rd;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int c = 0; c < CH; c++) rd_ptr[c] = 0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (seen[c]) begin
            in_data[8*c +: 8] = pkt[c][rd_ptr[c]];
            rd_ptr[c]++;
            if (rd_ptr[c] == LEN) begin
              rd_ptr[c] = 0;
              if (avail[c] > 0) avail[c]--;
              gen_pkt(c);
            end
          end
        end
      end
      upd_rdy();
    end
  end

  // Observation queues filled by the compare process.
  int sync_cyc_q[$], sync_ch_q[$], sync_dat_q[$];
  int rd_rise_q[$], v_rise_q[$], vlen_q[$];
  int b_gap_q[$], b_vlen_q[$];
  int err_cnt, err_al;

  task automatic clear_mon();
    sync_cyc_q.delete(); sync_ch_q.delete(); sync_dat_q.delete();
    rd_rise_q.delete(); v_rise_q.delete(); vlen_q.delete();
    b_gap_q.delete(); b_vlen_q.delete();
    err_cnt = 0;
    err_al  = 0;
  endtask

  // Reference model: a packet granted at decision cycle d is read in d+1..d+LEN,
  // appears on the output in d+3..d+LEN+2, and the next decision is at d+1+LEN+GAP.
  initial begin
    int cyc, next_dec, last, slot, off, pick;
    bit found;
    bit r_vld [2];
    int r_start [2];
    int r_ch [2];
    logic [7:0] r_dat [2][LEN];
    logic [CH-1:0] el, e_rd;
    logic e_v, e_s, e_e;
    logic [7:0] e_dat;
    logic [2:0] e_ch;
    logic prev_rd, prev_v, b_prev, b_had;
    int vrun, b_low, b_run;
    cyc = 0; next_dec = 1; last = CH - 1; slot = 0;
    r_vld[0] = 0; r_vld[1] = 0;
    e_dat = 8'h00; e_ch = 3'd0;
    prev_rd = 0; prev_v = 0; b_prev = 0; b_had = 0;
    vrun = 0; b_low = 0; b_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_pkt_rd", 32'(pkt_rd), 0);
        check("rst_ts_valid", 32'(ts_valid), 0);
        check("rst_ts_sync", 32'(ts_sync), 0);
        check("rst_ts_data", 32'(ts_data), 0);
        check("rst_ts_ch", 32'(ts_ch), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        r_vld[0] = 0; r_vld[1] = 0;
        last = CH - 1; e_dat = 8'h00; e_ch = 3'd0;
        next_dec = cyc + 1;
        prev_rd = 0; prev_v = 0; vrun = 0;
        b_prev = 0; b_had = 0; b_low = 0; b_run = 0;
      end else begin
        if (cyc == next_dec) begin
          el = pkt_rdy & ch_ena;
          found = 0; pick = 0;
          for (int k = 1; k <= CH; k++) begin
            if (!found && el[(last + k) % CH]) begin
              found = 1;
              pick = (last + k) % CH;
            end
          end
          if (found) begin
            slot = 1 - slot;
            r_vld[slot] = 1; r_start[slot] = cyc + 1; r_ch[slot] = pick;
            for (int k = 0; k < LEN; k++) r_dat[slot][k] = pkt[pick][k];
            last = pick;
            next_dec = cyc + 1 + LEN + GAP;
          end else begin
            next_dec = cyc + 1;
          end
        end
        e_rd = '0; e_v = 0; e_s = 0; e_e = 0;
        for (int s = 0; s < 2; s++) begin
          if (r_vld[s]) begin
            off = cyc - r_start[s];
            if (off >= 0 && off < LEN) e_rd[r_ch[s]] = 1'b1;
            if (off >= 2 && off < LEN + 2) begin
              e_v = 1;
              e_dat = r_dat[s][off-2];
              if (off == 2) begin
                e_s = 1;
                e_e = (r_dat[s][0] != 8'h47);
                e_ch = 3'(r_ch[s]);
              end
            end
          end
        end
        check("pkt_rd", 32'(pkt_rd), 32'(e_rd));
        check("ts_valid", 32'(ts_valid), 32'(e_v));
        check("ts_sync", 32'(ts_sync), 32'(e_s));
        check("sync_err", 32'(sync_err), 32'(e_e));
        check("ts_ch", 32'(ts_ch), 32'(e_ch));
        check("ts_data", 32'(ts_data), 32'(e_dat));

        if (pkt_rd != 0 && !prev_rd) rd_rise_q.push_back(cyc);
        if (ts_valid && !prev_v) v_rise_q.push_back(cyc);
        if (ts_valid) vrun++;
        else if (prev_v) begin vlen_q.push_back(vrun); vrun = 0; end
        if (ts_sync) begin
          sync_cyc_q.push_back(cyc); sync_ch_q.push_back(int'(ts_ch)); sync_dat_q.push_back(int'(ts_data));
        end
        if (sync_err) begin err_cnt++; if (ts_sync) err_al++; end
        prev_rd = (pkt_rd != 0);
        prev_v  = ts_valid;

        if (b_valid) begin
          if (!b_prev && b_had) b_gap_q.push_back(b_low);
          b_had = 1; b_low = 0; b_run++;
        end else begin
          if (b_prev) begin b_vlen_q.push_back(b_run); b_run = 0; end
          b_low++;
        end
        b_prev = b_valid;
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    tick(3);
    clear_mon();
    rst_n = 1'b1;
  endtask

  task automatic wait_syncs(input int n, input int budget);
    int k;
    k = 0;
    while (sync_cyc_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("sync_wait_timeout", 32'(sync_cyc_q.size() >= n), 1);
  endtask

  task automatic setup(input logic [CH-1:0] ena, input int av, input bit rmp);
    ch_ena = ena;
    for (int c = 0; c < CH; c++) begin
      avail[c] = ena[c] ? av : 0;
      ramp[c] = rmp;
      first_byte[c] = 8'h47;
      gen_pkt(c);
    end
    upd_rdy();
  endtask

  initial begin
    int exp_order [5];
    int k;
    in_data = '0;
    setup(4'b0000, 0, 0);
    clear_mon();
    #1 rst_n = 1'b0;

    // Single channel, ramp payload.
    setup(4'b0100, 1, 1);
    do_reset();
    wait_syncs(1, PERIOD + 50);
    tick(200);
    check("t1_rd_to_valid", 32'(v_rise_q[0] - rd_rise_q[0]), 2);
    check("t1_valid_len", 32'(vlen_q[0]), 188);
    check("t1_ts_ch", 32'(sync_ch_q[0]), 2);
    check("t1_sync_byte", 32'(sync_dat_q[0]), 32'h47);
    check("t1_sync_err_cnt", 32'(err_cnt), 0);
    check("t1_pkt_count", 32'(sync_cyc_q.size()), 1);

    // All four continuously requesting.
    setup(4'b1111, 1000, 0);
    do_reset();
    wait_syncs(5, 5 * PERIOD + 50);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 32'(sync_ch_q[i]), 32'(exp_order[i]));
    for (int i = 0; i < 4; i++) check($sformatf("t2_period%0d", i), 32'(sync_cyc_q[i+1] - sync_cyc_q[i]), 193);

    // Enable masking, then drop channel 1 while its packet is in flight.
    setup(4'b1010, 1000, 0);
    for (int c = 0; c < CH; c++) avail[c] = 1000;
    upd_rdy();
    do_reset();
    wait_syncs(3, 3 * PERIOD + 50);
    check("t3_order0", 32'(sync_ch_q[0]), 1);
    check("t3_order1", 32'(sync_ch_q[1]), 3);
    check("t3_order2", 32'(sync_ch_q[2]), 1);
    ch_ena[1] = 1'b0;
    wait_syncs(5, 2 * PERIOD + 50);
    tick(200);
    check("t3_inflight_len", 32'(vlen_q[2]), 188);
    check("t3_after3", 32'(sync_ch_q[3]), 3);
    check("t3_after4", 32'(sync_ch_q[4]), 3);

    // Bad sync byte on channel 0.
    setup(4'b0001, 1, 0);
    first_byte[0] = 8'h48;
    gen_pkt(0);
    do_reset();
    wait_syncs(1, PERIOD + 50);
    tick(250);
    check("t4_err_pulses", 32'(err_cnt), 1);
    check("t4_err_aligned", 32'(err_al), 1);
    check("t4_first_byte", 32'(sync_dat_q[0]), 32'h48);
    check("t4_valid_len", 32'(vlen_q[0]), 188);
    check("t4_pkt_count", 32'(sync_cyc_q.size()), 1);

    // Back-to-back on the gapless instance.
    setup(4'b0000, 0, 0);
    do_reset();
    k = 0;
    while (b_gap_q.size() < 3 && k < 1000) begin @(posedge clk); k++; end
    #2;
    check("t5_wait_timeout", 32'(b_gap_q.size() >= 3), 1);
    for (int i = 0; i < 3; i++) check($sformatf("t5_gap%0d", i), 32'(b_gap_q[i]), 1);
    check("t5_valid_len", 32'(b_vlen_q[0]), 188);

    // Reset in the middle of a packet from channel 1.
    setup(4'b1111, 1000, 0);
    avail[0] = 0;
    upd_rdy();
    do_reset();
    k = 0;
    while (rd_rise_q.size() < 1 && k < 50) begin @(posedge clk); k++; end
    #2;
    check("t6_grant_timeout", 32'(rd_rise_q.size()), 1);
    tick(100);
    check("t6_valid_before", 32'(ts_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_pkt_rd", 32'(pkt_rd), 0);
    check("t6_async_valid", 32'(ts_valid), 0);
    check("t6_async_sync", 32'(ts_sync), 0);
    avail[0] = 1000;
    upd_rdy();
    tick(3);
    clear_mon();
    rst_n = 1'b1;
    wait_syncs(1, PERIOD + 50);
    check("t6_first_grant", 32'(sync_ch_q[0]), 0);
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
